// File: rtl/radar_pkg.sv
// Shared defaults, FSM state encoding and flag bit positions
// for the radar frame packer and its scan counter.
package radar_pkg;

    localparam int DATA_WIDTH_D = 16;
    localparam int LANES_D      = 5;
    localparam int IDX_W_D      = 11;
    localparam int NUM_CH_D     = 4;

    // data_start bit positions
    localparam int DS_FRAME = 0;
    localparam int DS_ROW   = 1;

    // data_end bit positions
    localparam int DE_ROW   = 0;
    localparam int DE_FRAME = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/radar_scan_counter.sv
// Column/row/channel scan counters (column innermost) with one advance input.
// Ports: clock, reset, clear, advance, cfg_rows, cfg_cols in;
//        col, row, chan position and last_col/last_row/last_chan flags out.
module radar_scan_counter
    import radar_pkg::*;
#(
    parameter int IDX_W  = IDX_W_D,
    parameter int NUM_CH = NUM_CH_D
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W:0]   cfg_rows,
    input  logic [IDX_W:0]   cfg_cols,
    output logic [IDX_W-1:0] col,
    output logic [IDX_W-1:0] row,
    output logic [3:0]       chan,
    output logic             last_col,
    output logic             last_row,
    output logic             last_chan
);

    localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

    assign last_col  = ({1'b0, col} == cfg_cols - ONE);
    assign last_row  = ({1'b0, row} == cfg_rows - ONE);
    assign last_chan = (chan == 4'(NUM_CH - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col  <= '0;
            row  <= '0;
            chan <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row  <= '0;
                    chan <= last_chan ? 4'd0 : chan + 4'd1;
                end else begin
                    row <= row + IDX_W'(1);
                end
            end else begin
                col <= col + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/radar_frame_packer.sv
// Packs I/Q samples into LANES-wide beats scanned channel/row/column,
// tagging each beat with its positions and frame/row start/end flags.
// Ports: clock, reset, start, cfg_rows, cfg_cols, in_valid/in_ready/in_data,
//        out_valid/out_ready, pixel_out, row/col indices, channel_num,
//        data_start, data_end, busy, done, cfg_err.
module radar_frame_packer
    import radar_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int LANES      = LANES_D,
    parameter int IDX_W      = IDX_W_D,
    parameter int NUM_CH     = NUM_CH_D
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IDX_W:0]                cfg_rows,
    input  logic [IDX_W:0]                cfg_cols,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*DATA_WIDTH-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*LANES*2-1:0] pixel_out,
    output logic [IDX_W-1:0]              row_idx1,
    output logic [IDX_W-1:0]              col_idx1,
    output logic [IDX_W-1:0]              row_idx2,
    output logic [IDX_W-1:0]              col_idx2,
    output logic [3:0]                    channel_num,
    output logic [1:0]                    data_start,
    output logic [1:0]                    data_end,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam int PW = SW * LANES;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W:0] MAX_DIM = {1'b1, {IDX_W{1'b0}}};

    state_t state, state_next;

    logic [IDX_W:0]   rows_q, cols_q;
    logic [LW-1:0]    lane;
    logic [PW-1:0]    acc, beat_next;
    logic [IDX_W-1:0] row_first, col_first;
    logic [IDX_W-1:0] beat_row1, beat_col1;
    logic [IDX_W-1:0] col, row;
    logic [3:0]       chan;
    logic             last_col, last_row, last_chan;
    logic             cfg_ok, start_ok, xfer, close, handshake;

    assign cfg_ok = (cfg_rows != '0) && (cfg_cols != '0)
                 && (cfg_rows <= MAX_DIM) && (cfg_cols <= MAX_DIM);

    assign start_ok  = (state == ST_IDLE) && start && cfg_ok;
    assign busy      = (state == ST_RUN);
    assign in_ready  = busy && (!out_valid || out_ready);
    assign xfer      = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign close     = xfer && ((lane == LW'(LANES - 1)) || last_col);

    // Lane 0 position comes straight from the counters when the beat
    // both opens and closes on the same sample.
    assign beat_row1 = (lane == '0) ? row : row_first;
    assign beat_col1 = (lane == '0) ? col : col_first;

    radar_scan_counter #(
        .IDX_W  (IDX_W),
        .NUM_CH (NUM_CH)
    ) u_scan (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .advance   (xfer),
        .cfg_rows  (rows_q),
        .cfg_cols  (cols_q),
        .col       (col),
        .row       (row),
        .chan      (chan),
        .last_col  (last_col),
        .last_row  (last_row),
        .last_chan (last_chan)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        cfg_err    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_next = ST_RUN;
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (handshake && data_end[DE_FRAME]) begin
                    state_next = ST_IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (reset) begin
            state_next = ST_IDLE;
            done       = 1'b0;
            cfg_err    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rows_q <= '0;
            cols_q <= '0;
        end else if (start_ok) begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols;
        end
    end

    always_comb begin
        beat_next = acc;
        for (int k = 0; k < LANES; k++) begin
            if (lane == LW'(k)) begin
                beat_next[k*SW +: SW] = in_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lane        <= '0;
            acc         <= '0;
            row_first   <= '0;
            col_first   <= '0;
            out_valid   <= 1'b0;
            pixel_out   <= '0;
            row_idx1    <= '0;
            col_idx1    <= '0;
            row_idx2    <= '0;
            col_idx2    <= '0;
            channel_num <= '0;
            data_start  <= '0;
            data_end    <= '0;
        end else begin
            if (start_ok) begin
                lane <= '0;
                acc  <= '0;
            end else if (xfer) begin
                if (lane == '0) begin
                    row_first <= row;
                    col_first <= col;
                end
                if (close) begin
                    // Accumulator restarts clear so unused lanes read zero.
                    lane        <= '0;
                    acc         <= '0;
                    pixel_out   <= beat_next;
                    row_idx1    <= beat_row1;
                    col_idx1    <= beat_col1;
                    row_idx2    <= row;
                    col_idx2    <= col;
                    channel_num <= chan;
                    data_start[DS_FRAME] <= (chan == 4'd0)
                        && (beat_row1 == '0) && (beat_col1 == '0);
                    data_start[DS_ROW]   <= (beat_col1 == '0);
                    data_end[DE_ROW]     <= last_col;
                    data_end[DE_FRAME]   <= last_col && last_row
                                         && last_chan;
                end else begin
                    lane <= lane + LW'(1);
                    acc  <= beat_next;
                end
            end
            if (close) begin
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_radar_frame_packer.sv
// Scoreboard bench for radar_frame_packer: a reference packer pushes
// expected beats as samples are driven; a monitor compares DUT beats.
module tb_radar_frame_packer;

    localparam int DW = 8;
    localparam int LN = 5;
    localparam int IW = 4;
    localparam int NC = 2;
    localparam int SW = 2 * DW;
    localparam int PW = SW * LN;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic [IW-1:0] r1;
        logic [IW-1:0] c1;
        logic [IW-1:0] r2;
        logic [IW-1:0] c2;
        logic [3:0]    ch;
        logic [1:0]    ds;
        logic [1:0]    de;
    } beat_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic [IW:0]   cfg_rows;
    logic [IW:0]   cfg_cols;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] pixel_out;
    logic [IW-1:0] row_idx1, col_idx1, row_idx2, col_idx2;
    logic [3:0]    channel_num;
    logic [1:0]    data_start, data_end;
    logic          busy, done, cfg_err;

    radar_frame_packer #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .IDX_W      (IW),
        .NUM_CH     (NC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cfg_rows    (cfg_rows),
        .cfg_cols    (cfg_cols),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pixel_out   (pixel_out),
        .row_idx1    (row_idx1),
        .col_idx1    (col_idx1),
        .row_idx2    (row_idx2),
        .col_idx2    (col_idx2),
        .channel_num (channel_num),
        .data_start  (data_start),
        .data_end    (data_end),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int    n_tests  = 0;
    int    n_fail   = 0;
    int    seq      = 0;
    int    done_cnt = 0;
    int    exp_done = 0;
    beat_t q[$];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: any visible beat must match the scoreboard head,
    // including every cycle it is held under back-pressure.
    always @(negedge clock) begin
        beat_t got;
        if (!reset && out_valid) begin
            got = {pixel_out, row_idx1, col_idx1, row_idx2, col_idx2,
                   channel_num, data_start, data_end};
            if (q.size() == 0) begin
                chk("unexpected_beat", 128'(got), 128'(0));
            end else begin
                chk("beat", 128'(got), 128'(q[0]));
                if (out_ready) begin
                    chk("done", 128'(done), 128'(q[0].de[1]));
                    if (done) done_cnt++;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic pulse_start(input int rows, input int cols,
                               input bit exp_err, input bit exp_busy);
        cfg_rows = (IW+1)'(rows);
        cfg_cols = (IW+1)'(cols);
        start    = 1'b1;
        @(negedge clock);
        chk("cfg_err", 128'(cfg_err), 128'(exp_err));
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        chk("busy_after_start", 128'(busy), 128'(exp_busy));
        chk("cfg_err_pulse", 128'(cfg_err), 128'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic drive_frame(input int rows, input int cols,
                               input int max_samples, input bit gaps);
        logic [PW-1:0] acc;
        logic [SW-1:0] d;
        beat_t         b;
        int            lane;
        int            r1, c1, n, t;
        bit            ok;
        acc  = '0;
        lane = 0;
        n    = 0;
        r1   = 0;
        c1   = 0;
        for (int ch = 0; ch < NC; ch++) begin
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < cols; c++) begin
                    if (max_samples >= 0 && n == max_samples) begin
                        in_valid = 1'b0;
                        return;
                    end
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clock);
                        #1;
                    end
                    d = {8'(seq * 7 + 3), 8'(seq)};
                    seq++;
                    if (lane == 0) begin
                        r1 = r;
                        c1 = c;
                    end
                    acc[lane*SW +: SW] = d;
                    if (lane == LN - 1 || c == cols - 1) begin
                        b.pix = acc;
                        b.r1  = IW'(r1);
                        b.c1  = IW'(c1);
                        b.r2  = IW'(r);
                        b.c2  = IW'(c);
                        b.ch  = 4'(ch);
                        b.ds  = {c1 == 0, ch == 0 && r1 == 0 && c1 == 0};
                        b.de  = {c == cols - 1 && r == rows - 1
                                 && ch == NC - 1, c == cols - 1};
                        q.push_back(b);
                        acc  = '0;
                        lane = 0;
                    end else begin
                        lane++;
                    end
                    in_valid = 1'b1;
                    in_data  = d;
                    ok = 1'b0;
                    t  = 0;
                    while (!ok && t < 100) begin
                        @(negedge clock);
                        ok = in_ready;
                        t++;
                    end
                    if (!ok) begin
                        chk("in_ready_timeout", 128'(0), 128'(1));
                        in_valid = 1'b0;
                        return;
                    end
                    @(posedge clock);
                    #1;
                    n++;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clock);
            ok = (q.size() == 0) && !busy;
        end
        chk("idle_timeout", 128'(ok), 128'(1));
        chk("done_count", 128'(done_cnt), 128'(exp_done));
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ctl"},
            128'({out_valid, in_ready, busy, done, cfg_err}), 128'(0));
        chk({tag, "_beat"},
            128'({pixel_out, row_idx1, col_idx1, row_idx2, col_idx2,
                  channel_num, data_start, data_end}), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_rows  = '0;
        cfg_cols  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 2x10 per channel: beats split at col 5 and row end
        pulse_start(2, 10, 1'b0, 1'b1);
        drive_frame(2, 10, -1, 1'b0);
        exp_done++;
        wait_idle();

        // short last beat with zeroed upper lanes, idle input gaps
        pulse_start(1, 7, 1'b0, 1'b1);
        drive_frame(1, 7, -1, 1'b1);
        exp_done++;
        wait_idle();

        // back-pressure for 20 cycles after the first beat
        pulse_start(2, 10, 1'b0, 1'b1);
        fork
            drive_frame(2, 10, -1, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clock);
                    seen = out_valid;
                end
                chk("first_beat_timeout", 128'(seen), 128'(1));
                @(posedge clock);
                #1;
                out_ready = 1'b0;
                repeat (15) @(negedge clock);
                chk("in_ready_stalled", 128'(in_ready), 128'(0));
                chk("out_valid_stalled", 128'(out_valid), 128'(1));
                repeat (5) @(negedge clock);
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        exp_done++;
        wait_idle();

        // invalid configurations, then the largest legal one
        pulse_start(2, 0, 1'b1, 1'b0);
        pulse_start(0, 3, 1'b1, 1'b0);
        pulse_start(17, 3, 1'b1, 1'b0);
        pulse_start(1, 16, 1'b0, 1'b1);
        drive_frame(1, 16, -1, 1'b1);
        exp_done++;
        wait_idle();

        // start during RUN must not disturb the 2x3 frame
        pulse_start(2, 3, 1'b0, 1'b1);
        fork
            drive_frame(2, 3, -1, 1'b0);
            begin
                repeat (3) @(posedge clock);
                #1;
                pulse_start(1, 1, 1'b0, 1'b1);
            end
        join
        exp_done++;
        wait_idle();

        // reset mid-row, then a clean restart
        pulse_start(2, 10, 1'b0, 1'b1);
        drive_frame(2, 10, 7, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_zero_outputs("mid_reset");
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        pulse_start(2, 3, 1'b0, 1'b1);
        drive_frame(2, 3, -1, 1'b1);
        exp_done++;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/radar_frame_packer.md
RADAR_FRAME_PACKER -- requirements
Module: radar_frame_packer

Interface
REQ-001 SHALL take parameters (name, default, meaning): DATA_WIDTH, 16, bits per I or Q component.
REQ-002 SHALL take LANES, 5, complex samples per output beat (1..8).
REQ-003 SHALL take IDX_W, 11, row/column index width; MAX_ROWS = MAX_COLS = 2**IDX_W.
REQ-004 SHALL take NUM_CH, 4, channels per frame (1..16); channel_num width fixed at 4.
REQ-005 SHALL have ports in this order (name, direction, width, meaning): clock, in, 1, single clock; all logic on its rising edge.
REQ-006 reset, in, 1, synchronous, active-high.
REQ-007 start, in, 1, one-cycle pulse; latches cfg_rows and cfg_cols and begins a frame.
REQ-008 cfg_rows, in, IDX_W+1, rows per channel. cfg_cols, in, IDX_W+1, columns per row.
REQ-009 in_valid, in, 1 / in_ready, out, 1 / in_data, in, 2*DATA_WIDTH: sample stream; I in upper half, Q in lower half.
REQ-010 out_valid, out, 1 / out_ready, in, 1: beat handshake.
REQ-011 pixel_out, out, DATA_WIDTH*LANES*2: lane k occupies bits [(k+1)*2*DATA_WIDTH-1 : k*2*DATA_WIDTH].
REQ-012 row_idx1, col_idx1, out, IDX_W each: position of lane 0. row_idx2, col_idx2, out, IDX_W each: position of the last valid lane.
REQ-013 channel_num, out, 4: channel of the beat.
REQ-014 data_start, out, 2: bit0 = frame start, bit1 = row start. data_end, out, 2: bit0 = row end, bit1 = frame end.
REQ-015 busy, out, 1 / done, out, 1 (one-cycle pulse) / cfg_err, out, 1 (one-cycle pulse).

Function
REQ-016 Scan order SHALL be channel outermost, then row, then column; all counters count from 0.
REQ-017 States SHALL be IDLE and RUN. IDLE->RUN on start with valid configuration. RUN->IDLE on the out_valid&&out_ready cycle of the frame-end beat; done pulses in that same cycle.
REQ-018 On start with cfg_rows or cfg_cols equal to 0, or greater than 2**IDX_W: cfg_err SHALL pulse for one cycle; state stays IDLE.
REQ-019 start while in RUN SHALL be ignored; latched configuration is unchanged.
REQ-020 in_ready SHALL equal RUN && (!out_valid || out_ready).
REQ-021 Sample transfer occurs on in_valid&&in_ready. Each sample SHALL be written to the current lane of the pack register.
REQ-022 A beat SHALL close when lane LANES-1 is filled or the sample is the last column of a row. Columns SHALL NOT span rows.
REQ-023 A closed beat SHALL appear on out_valid on the cycle after the closing transfer, with all beat fields registered. Lanes beyond the last valid lane SHALL be zero.
REQ-024 out_valid and all beat fields SHALL hold stable until out_ready is sampled high.
REQ-025 data_start[0] SHALL be set only on channel 0, row 0, column 0. data_start[1] SHALL be set on every beat whose col_idx1 is 0.
REQ-026 data_end[0] SHALL be set on every beat containing the last column of a row. data_end[1] SHALL be set on the final beat of channel NUM_CH-1, row cfg_rows-1.
REQ-027 The column counter SHALL wrap from cfg_cols-1 to 0 and increment the row counter. The row counter SHALL wrap from cfg_rows-1 to 0 and increment channel_num.
REQ-028 Simultaneous output handshake and closing input transfer SHALL load the new beat with no bubble, sustaining one beat per LANES input cycles.
REQ-029 busy SHALL equal (state == RUN).

Reset
REQ-030 Reset SHALL force IDLE, all counters 0, out_valid=0, in_ready=0, busy=0, done=0, cfg_err=0, and pixel_out, all indices, channel_num, data_start and data_end to 0.
REQ-031 Reset mid-frame SHALL discard partial and pending beats; the first beat after the next start SHALL carry data_start=2'b11.

Structure
REQ-032 Package radar_pkg SHALL hold the default parameters, the state enum, and localparams for the data_start/data_end bit positions.
REQ-033 Sub-module radar_scan_counter SHALL implement the column/row/channel wrap counters with a single advance input; its parent instantiates it once.

Verification
REQ-034 LANES=5, cols=10, rows=2, NUM_CH=1, out_ready=1: 4 beats; beat0 data_start=11, col 0..4; beat1 data_end=01; beat3 data_end=11, done pulses.
REQ-035 cols=7, LANES=5: beat1 has col_idx1=5, col_idx2=6, lanes 2..4 zero, data_end[0]=1.
REQ-036 out_ready held low for 20 cycles after the first beat: fields stable; in_ready low once the second beat closes; no sample lost.
REQ-037 start with cfg_cols=0 -> cfg_err pulse, busy stays 0. start during RUN -> ignored, frame completes with the original configuration.
REQ-038 NUM_CH=2, rows=2, cols=3: channel_num 0,0,1,1; data_end=11 only on the last beat.
REQ-039 Reset asserted mid-row, then restart: outputs zero during reset; the next frame is correct from row 0, column 0.
